mips_multicycle_ctrl: RTL and testbench

Multicycle control FSM that sequences the shared-ALU MIPS datapath (PC register, register file, ALU, sign-extend/shift, result muxes) around one unified instruction/data memory port. It decodes op/funct once per instruction and drives every datapath enable and mux select each cycle. Memory accesses use a req/ready handshake, so the FSM stalls until memory answers. It also keeps a retired-instruction counter and flags illegal opcodes.

---
 rtl/mips_ctrl_pkg.sv | 66 ++++++
 rtl/mips_multicycle_ctrl_alu_decode.sv | 36 +++
 rtl/mips_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control FSM: state encoding,
// opcode/funct constants, ALU control codes and datapath mux encodings.
// Optional feature macro: MIPS_JAL_EN (adds the JAL state usage in the top).
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (Instr[5:0])
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    // pc_src encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // alu_src_b encodings
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// -----------------------------------------------------------------------------
// mips_alu_decode
// Combinational R-type funct decoder.
// Ports:
//   funct     in  6  Instr[5:0]
//   alu_ctrl  out 4  ALU operation for the funct (ADD when not an ALU op)
//   is_jr     out 1  funct is JR (handled by the FSM, not the ALU)
//   bad_funct out 1  funct is not supported
// -----------------------------------------------------------------------------
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       is_jr,
    output logic       bad_funct
);

    always_comb begin
        alu_ctrl  = ALU_ADD;
        is_jr     = 1'b0;
        bad_funct = 1'b0;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            FN_SLL:  alu_ctrl = ALU_SLL;
            FN_SRL:  alu_ctrl = ALU_SRL;
            FN_JR:   is_jr    = 1'b1;
            default: bad_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multicycle control FSM for a shared-ALU MIPS datapath with one unified
// instruction/data memory port (req/ready handshake). Also counts retired
// instructions and pulses `illegal` on unsupported opcodes/functs.
//
// Optional feature macro: MIPS_JAL_EN
//   defined   : JAL (op 000011) is supported; adds link_dst/link_data outputs
//   undefined : JAL is treated as an illegal opcode; no link ports
//
// Ports:
//   clk, reset (async, active-high)
//   op, funct, zero, mem_ready                              inputs
//   mem_req, mem_we, iord, ir_we, pc_en, reg_we, reg_dst,
//   mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctrl      datapath controls
//   instret                                                 retired count
//   illegal                                                 illegal pulse
//   link_dst, link_data                                     (MIPS_JAL_EN only)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_en,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [3:0]       alu_ctrl,
    output logic [CNT_W-1:0] instret,
`ifdef MIPS_JAL_EN
    output logic             link_dst,
    output logic             link_data,
`endif
    output logic             illegal
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    logic [3:0] dec_alu_ctrl;
    logic       dec_is_jr;
    logic       dec_bad_funct;

    mips_alu_decode u_alu_decode (
        .funct     (funct),
        .alu_ctrl  (dec_alu_ctrl),
        .is_jr     (dec_is_jr),
        .bad_funct (dec_bad_funct)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign instret = instret_q;

    // Outputs are forced low while reset is held so an access in flight is
    // withdrawn immediately, not at the next clock edge.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_en      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        pc_src     = PCSRC_ALU;
        alu_ctrl   = ALU_AND;
        illegal    = 1'b0;
`ifdef MIPS_JAL_EN
        link_dst   = 1'b0;
        link_data  = 1'b0;
`endif
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_ctrl  = ALU_ADD;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_en   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Branch target is computed here speculatively into ALUOut.
                    alu_src_b = SRCB_IMM_SH2;
                    alu_ctrl  = ALU_ADD;
                    case (op)
                        OP_LW, OP_SW:   state_d = S_MEMADR;
                        OP_RTYPE:       state_d = S_EXEC;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_ADDI:        state_d = S_ADDIEX;
                        OP_J:           state_d = S_JUMP;
`ifdef MIPS_JAL_EN
                        OP_JAL:         state_d = S_JAL;
`endif
                        default: begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_ctrl  = ALU_ADD;
                    state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                    retire     = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_RT;
                    alu_ctrl  = dec_alu_ctrl;
                    if (dec_is_jr) begin
                        pc_src  = PCSRC_RS;
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else if (dec_bad_funct) begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_ALUWB;
                    end
                end
                S_ALUWB: begin
                    reg_we  = 1'b1;
                    reg_dst = 1'b1;
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_RT;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_en     = (op == OP_BNE) ? ~zero : zero;
                    state_d   = S_FETCH;
                    retire    = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_ctrl  = ALU_ADD;
                    state_d   = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_we  = 1'b1;
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                S_JUMP: begin
                    pc_src  = PCSRC_JUMP;
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
`ifdef MIPS_JAL_EN
                S_JAL: begin
                    pc_src    = PCSRC_JUMP;
                    pc_en     = 1'b1;
                    reg_we    = 1'b1;
                    link_dst  = 1'b1;
                    link_data = 1'b1;
                    state_d   = S_FETCH;
                    retire    = 1'b1;
                end
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Directed self-checking bench for mips_multicycle_ctrl. Each test starts in
// FETCH one time unit after a rising edge; outputs are sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_we, pc_en, reg_we, reg_dst;
    logic        mem_to_reg, alu_src_a, illegal;
    logic [1:0]  alu_src_b, pc_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] instret;
`ifdef MIPS_JAL_EN
    logic        link_dst, link_data;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int exp_ret = 0;

    logic [5:0] fn_tab  [7];
    logic [3:0] alu_tab [7];

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_en      (pc_en),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_ctrl   (alu_ctrl),
        .instret    (instret),
`ifdef MIPS_JAL_EN
        .link_dst   (link_dst),
        .link_data  (link_data),
`endif
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_branch(input logic [5:0] opc, input logic z, input logic exp_pcen);
        op = opc; mem_ready = 1'b1;
        next();                 // DECODE
        next();                 // BRANCH
        zero = z;
        #1;
        chk("br_pc_en", pc_en, exp_pcen);
        chk("br_pc_src", pc_src, 2'b01);
        chk("br_alu", alu_ctrl, 4'b0110);
        next();                 // FETCH
        exp_ret++;
        chk("br_instret", instret, exp_ret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1);
    end

    initial begin
        fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010};
        alu_tab = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1000,   4'b1001};

        reset = 1'b1; mem_ready = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
        #7;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_srcb", alu_src_b, 0);
        chk("rst_instret", instret, 0);
        #5 reset = 1'b0;        // t=12, between edges
        #1;

        // R-type ADD, zero wait states
        chk("f_mem_req", mem_req, 1);
        chk("f_ir_we", ir_we, 1);
        chk("f_pc_en", pc_en, 1);
        chk("f_srcb", alu_src_b, 2'b01);
        chk("f_alu", alu_ctrl, 4'b0010);
        next();
        chk("d_srcb", alu_src_b, 2'b11);
        chk("d_mem_req", mem_req, 0);
        next();
        chk("e_srca", alu_src_a, 1);
        chk("e_srcb", alu_src_b, 2'b00);
        chk("e_alu", alu_ctrl, 4'b0010);
        next();
        chk("wb_reg_we", reg_we, 1);
        chk("wb_reg_dst", reg_dst, 1);
        chk("wb_instret_before", instret, 0);
        next();
        exp_ret = 1;
        chk("r_instret", instret, exp_ret);

        // FETCH stalls while memory is not ready
        mem_ready = 1'b0;
        #1;
        chk("fw_mem_req", mem_req, 1);
        chk("fw_ir_we", ir_we, 0);
        chk("fw_pc_en", pc_en, 0);
        next();
        chk("fw_still_fetch", alu_src_b, 2'b01);
        mem_ready = 1'b1;

        // Every supported ALU funct
        for (int i = 0; i < 7; i++) begin
            op = 6'b000000; funct = fn_tab[i];
            next();             // DECODE
            next();             // EXEC
            chk("exec_alu", alu_ctrl, alu_tab[i]);
            next();             // ALUWB
            next();             // FETCH
            exp_ret++;
        end
        chk("rloop_instret", instret, exp_ret);

        // LW with three wait cycles in MEMRD (8 cycles total)
        op = 6'b100011;
        next();                 // DECODE
        next();                 // MEMADR
        chk("ma_srca", alu_src_a, 1);
        chk("ma_srcb", alu_src_b, 2'b10);
        mem_ready = 1'b0;
        next();                 // MEMRD
        for (int w = 0; w < 4; w++) begin
            if (w == 3) mem_ready = 1'b1;
            #1;
            chk("mr_mem_req", mem_req, 1);
            chk("mr_iord", iord, 1);
            next();
        end
        chk("mwb_reg_we", reg_we, 1);
        chk("mwb_mem_to_reg", mem_to_reg, 1);
        chk("mwb_reg_dst", reg_dst, 0);
        next();
        exp_ret++;
        chk("lw_instret", instret, exp_ret);
        chk("lw_back_fetch", mem_req, 1);

        // Branches
        do_branch(6'b000100, 1'b1, 1'b1);   // BEQ taken
        do_branch(6'b000100, 1'b0, 1'b0);   // BEQ not taken
        do_branch(6'b000101, 1'b0, 1'b1);   // BNE taken
        do_branch(6'b000101, 1'b1, 1'b0);   // BNE not taken

        // Illegal opcode
        op = 6'b111111;
        next();                 // DECODE
        chk("iop_illegal", illegal, 1);
        next();
        chk("iop_fetch", mem_req, 1);
        chk("iop_no_pulse", illegal, 0);
        chk("iop_instret", instret, exp_ret);

        // Illegal funct
        op = 6'b000000; funct = 6'b111111;
        next(); next();         // EXEC
        chk("ifn_illegal", illegal, 1);
        next();
        chk("ifn_no_wb", reg_we, 0);
        chk("ifn_fetch", mem_req, 1);
        chk("ifn_instret", instret, exp_ret);

        // JR
        funct = 6'b001000;
        next(); next();         // EXEC
        chk("jr_pc_en", pc_en, 1);
        chk("jr_pc_src", pc_src, 2'b11);
        next();
        exp_ret++;
        chk("jr_instret", instret, exp_ret);

        // ADDI
        op = 6'b001000;
        next(); next();         // ADDIEX
        chk("addi_srcb", alu_src_b, 2'b10);
        next();                 // ADDIWB
        chk("addi_reg_we", reg_we, 1);
        chk("addi_reg_dst", reg_dst, 0);
        next();
        exp_ret++;
        chk("addi_instret", instret, exp_ret);

        // J
        op = 6'b000010;
        next(); next();         // JUMP
        chk("j_pc_src", pc_src, 2'b10);
        chk("j_pc_en", pc_en, 1);
        next();
        exp_ret++;
        chk("j_instret", instret, exp_ret);

        // JAL
        op = 6'b000011;
        next();                 // DECODE
`ifdef MIPS_JAL_EN
        next();                 // JAL
        chk("jal_pc_en", pc_en, 1);
        chk("jal_reg_we", reg_we, 1);
        chk("jal_link_dst", link_dst, 1);
        chk("jal_link_data", link_data, 1);
        next();
        exp_ret++;
        chk("jal_instret", instret, exp_ret);
`else
        chk("jal_illegal", illegal, 1);
        next();
        chk("jal_instret", instret, exp_ret);
`endif

        // SW, then asynchronous reset in the middle of MEMWR
        op = 6'b101011;
        next(); next();         // MEMADR
        mem_ready = 1'b0;
        next();                 // MEMWR
        #1;
        chk("mw_mem_we", mem_we, 1);
        chk("mw_iord", iord, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_instret", instret, 0);
        #3 reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("arst_fetch_srcb", alu_src_b, 2'b01);
        chk("arst_fetch_ir_we", ir_we, 1);

        // SW with no wait states retires normally
        next(); next();         // MEMADR
        next();                 // MEMWR
        chk("sw_mem_we", mem_we, 1);
        next();
        chk("sw_instret", instret, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
